// File: rtl/ddr2_sys_st_bytes_to_packets_if.sv
// rtl/ddr2_sys_st_bytes_to_packets_if.sv - escaped byte stream in, Avalon-ST packet stream out
interface ddr2_sys_st_bytes_to_packets_if #(
  parameter int CHAN_W = 8
);
  logic              in_ready;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              out_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_startofpacket;
  logic              out_endofpacket;
  logic [CHAN_W-1:0] out_channel;

  modport slave (
    output in_ready,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_startofpacket,
    output out_endofpacket,
    output out_channel
  );

  modport master (
    input  in_ready,
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_startofpacket,
    input  out_endofpacket,
    input  out_channel
  );
endinterface

// File: rtl/ddr2_sys_st_bytes_to_packets.sv
// rtl/ddr2_sys_st_bytes_to_packets.sv - decodes escaped bytes into a registered packet stream
// Optional B2P_PROTO_ERR_EN adds a proto_err pulse for SOP-inside-packet and data-outside-packet.
module ddr2_sys_st_bytes_to_packets #(
  parameter int CHAN_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  ddr2_sys_st_bytes_to_packets_if.slave st
`ifdef B2P_PROTO_ERR_EN
  ,
  output logic proto_err
`endif
);
  localparam logic [7:0] SOP_B  = 8'h7A;
  localparam logic [7:0] EOP_B  = 8'h7B;
  localparam logic [7:0] CHAN_B = 8'h7C;
  localparam logic [7:0] ESC_B  = 8'h7D;

  logic              sop_pend;
  logic              eop_pend;
  logic              chan_pend;
  logic              esc_pend;
  logic [CHAN_W-1:0] chan_reg;

  logic       accept;
  logic       is_ctrl;
  logic       emit;
  logic [7:0] val;

  assign st.in_ready = !st.out_valid || st.out_ready;
  assign accept      = st.in_valid && st.in_ready;
  assign val         = esc_pend ? (st.in_data ^ 8'h20) : st.in_data;
  // An escaped byte is never a control code, even if it decodes to one.
  assign is_ctrl     = !esc_pend && (st.in_data >= SOP_B) && (st.in_data <= ESC_B);
  assign emit        = accept && !is_ctrl && !chan_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sop_pend  <= 1'b0;
      eop_pend  <= 1'b0;
      chan_pend <= 1'b0;
      esc_pend  <= 1'b0;
      chan_reg  <= '0;
    end else if (accept) begin
      if (is_ctrl) begin
        case (st.in_data)
          SOP_B: begin
            sop_pend  <= 1'b1;
            chan_pend <= 1'b0;
          end
          EOP_B: begin
            eop_pend  <= 1'b1;
            chan_pend <= 1'b0;
          end
          CHAN_B:  chan_pend <= 1'b1;
          default: esc_pend  <= 1'b1;
        endcase
      end else begin
        esc_pend <= 1'b0;
        if (chan_pend) begin
          chan_reg  <= val[CHAN_W-1:0];
          chan_pend <= 1'b0;
        end else begin
          sop_pend <= 1'b0;
          eop_pend <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st.out_valid         <= 1'b0;
      st.out_data          <= 8'h00;
      st.out_startofpacket <= 1'b0;
      st.out_endofpacket   <= 1'b0;
      st.out_channel       <= '0;
    end else if (emit) begin
      st.out_valid         <= 1'b1;
      st.out_data          <= val;
      st.out_startofpacket <= sop_pend;
      st.out_endofpacket   <= eop_pend;
      st.out_channel       <= chan_reg;
    end else if (st.out_ready) begin
      st.out_valid <= 1'b0;
    end
  end

`ifdef B2P_PROTO_ERR_EN
  logic pkt_open;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_open  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= (accept && is_ctrl && (st.in_data == SOP_B) && pkt_open) ||
                   (emit && !pkt_open && !sop_pend);
      if (emit) begin
        pkt_open <= (pkt_open || sop_pend) && !eop_pend;
      end
    end
  end
`endif
endmodule

// File: tb/tb_ddr2_sys_st_bytes_to_packets.sv
// tb/tb_ddr2_sys_st_bytes_to_packets.sv - directed and random decode checks against a stream model
module tb_ddr2_sys_st_bytes_to_packets;
  localparam int CHAN_W = 8;
  localparam logic [7:0] CH_MASK = 8'((1 << CHAN_W) - 1);

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [7:0] ch;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ddr2_sys_st_bytes_to_packets_if #(.CHAN_W(CHAN_W)) st_if ();
`ifdef B2P_PROTO_ERR_EN
  logic proto_err;
`endif

  ddr2_sys_st_bytes_to_packets #(.CHAN_W(CHAN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .st        (st_if)
`ifdef B2P_PROTO_ERR_EN
    ,
    .proto_err (proto_err)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int err_pulses;

  beat_t      exp_q[$];
  beat_t      cap_q[$];
  int         beat_of[$];
  bit         err_of[$];
  logic [7:0] stim[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] cur_out();
    return {st_if.out_valid, st_if.out_data, st_if.out_startofpacket,
            st_if.out_endofpacket, 8'(st_if.out_channel)};
  endfunction

  // Stream-level reference: walks the whole byte list and lists the beats it must yield.
  task automatic build_model(input logic [7:0] b[$]);
    bit sop, eop, chp, esc, open, data, err;
    logic [7:0] ch, x, v;
    sop = 0; eop = 0; chp = 0; esc = 0; open = 0; ch = 8'h00;
    exp_q.delete(); beat_of.delete(); err_of.delete();
    foreach (b[i]) begin
      x = b[i]; v = x; data = 0; err = 0;
      if (esc) begin
        esc = 0; v = x ^ 8'h20;
        if (chp) begin ch = v & CH_MASK; chp = 0; end
        else data = 1;
      end else if (x == 8'h7D) esc = 1;
      else if (x == 8'h7A) begin err = open; sop = 1; chp = 0; end
      else if (x == 8'h7B) begin eop = 1; chp = 0; end
      else if (x == 8'h7C) chp = 1;
      else if (chp) begin ch = x & CH_MASK; chp = 0; end
      else data = 1;
      if (data) begin
        err = !open && !sop;
        beat_of.push_back(exp_q.size());
        exp_q.push_back('{data: v, sop: sop, eop: eop, ch: ch});
        open = (open || sop) && !eop;
        sop = 0; eop = 0;
      end else begin
        beat_of.push_back(-1);
      end
      err_of.push_back(err);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    st_if.in_valid = 1'b0;
    st_if.in_data = 8'h00;
    st_if.out_ready = 1'b1;
    #1;
    check("rst_outs", 32'(cur_out()), 32'h0);
    check("rst_in_ready", 32'(st_if.in_ready), 32'h1);
`ifdef B2P_PROTO_ERR_EN
    check("rst_proto_err", 32'(proto_err), 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // mode 0: always ready, no gaps; 1: random gaps and backpressure; 2: 5-cycle stall on first beat
  task automatic run_group(input logic [7:0] b[$], input int mode, input bit rst);
    int idx, got, last_acc, cyc, stall_cnt;
    bit held;
    logic [18:0] snap;
    if (rst) do_reset();
    build_model(b);
    cap_q.delete();
    idx = 0; got = 0; last_acc = -1; cyc = 0; stall_cnt = 0; held = 0; snap = '0;
    err_pulses = 0;
    while ((idx < b.size() || got < exp_q.size() || last_acc >= 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
`ifdef B2P_PROTO_ERR_EN
      check("proto_err", 32'(proto_err), 32'(last_acc >= 0 && err_of[last_acc]));
      if (proto_err === 1'b1) err_pulses++;
`endif
      if (last_acc >= 0 && beat_of[last_acc] >= 0)
        check("latency", 32'(cur_out()), 32'({1'b1, exp_q[beat_of[last_acc]]}));
      if (held) check("hold_stable", 32'(cur_out()), 32'(snap));

      st_if.in_valid = (idx < b.size()) && (mode != 1 || $urandom_range(0, 3) != 0);
      st_if.in_data = (idx < b.size()) ? b[idx] : 8'h00;
      case (mode)
        1: st_if.out_ready = ($urandom_range(0, 1) == 1);
        2: begin
          if (st_if.out_valid && stall_cnt < 5) begin
            st_if.out_ready = 1'b0;
            stall_cnt++;
          end else begin
            st_if.out_ready = 1'b1;
          end
        end
        default: st_if.out_ready = 1'b1;
      endcase
      #1;
      check("in_ready", 32'(st_if.in_ready), 32'(!st_if.out_valid || st_if.out_ready));
      if (st_if.in_valid && st_if.in_ready) begin
        last_acc = idx;
        idx++;
      end else begin
        last_acc = -1;
      end
      if (st_if.out_valid && st_if.out_ready) begin
        cap_q.push_back(beat_t'(cur_out()));
        if (got < exp_q.size()) check("beat", 32'(cur_out()), 32'({1'b1, exp_q[got]}));
        else check("extra_beat", 32'(got), 32'(exp_q.size()));
        got++;
      end
      held = st_if.out_valid && !st_if.out_ready;
      snap = cur_out();
    end
    check("bytes_consumed", 32'(idx), 32'(b.size()));
    check("beat_count", 32'(got), 32'(exp_q.size()));
    st_if.in_valid = 1'b0;
  endtask

  initial begin
    st_if.in_valid = 1'b0;
    st_if.in_data = 8'h00;
    st_if.out_ready = 1'b1;

    stim = '{8'h7A, 8'h7C, 8'h03, 8'h11, 8'h22, 8'h7B, 8'h33};
    run_group(stim, 0, 1);
    check("t1_n", 32'(cap_q.size()), 32'd3);
    check("t1_b0", 32'(cap_q[0]), 32'({8'h11, 1'b1, 1'b0, 8'h03}));
    check("t1_b1", 32'(cap_q[1]), 32'({8'h22, 1'b0, 1'b0, 8'h03}));
    check("t1_b2", 32'(cap_q[2]), 32'({8'h33, 1'b0, 1'b1, 8'h03}));

    stim = '{8'h7A, 8'h7B, 8'h7D, 8'h5A};
    run_group(stim, 0, 1);
    check("t2_b0", 32'(cap_q[0]), 32'({8'h7A, 1'b1, 1'b1, 8'h00}));

    stim = '{8'h7C, 8'h7D, 8'h5D, 8'h7A, 8'h7B, 8'h44};
    run_group(stim, 0, 1);
    check("t3_b0", 32'(cap_q[0]), 32'({8'h44, 1'b1, 1'b1, 8'h7D}));

    stim = '{8'h7A, 8'h01, 8'h02, 8'h7B, 8'h03};
    run_group(stim, 2, 1);
    check("t4_n", 32'(cap_q.size()), 32'd3);
    check("t4_b0", 32'(cap_q[0]), 32'({8'h01, 1'b1, 1'b0, 8'h00}));
    check("t4_b2", 32'(cap_q[2]), 32'({8'h03, 1'b0, 1'b1, 8'h00}));

    stim = '{8'h7A, 8'h7C};
    run_group(stim, 0, 1);
    do_reset();
    stim = '{8'h55};
    run_group(stim, 0, 0);
    check("t5_b0", 32'(cap_q[0]), 32'({8'h55, 1'b0, 1'b0, 8'h00}));

    @(negedge clk);
    st_if.out_ready = 1'b0;
    st_if.in_valid = 1'b1;
    st_if.in_data = 8'h42;
    @(negedge clk);
    st_if.in_valid = 1'b0;
    check("t6_loaded", 32'(st_if.out_valid), 32'h1);
    do_reset();

`ifdef B2P_PROTO_ERR_EN
    stim = '{8'h7A, 8'h10, 8'h7A, 8'h20, 8'h7B, 8'h30, 8'h66};
    run_group(stim, 0, 1);
    check("t7_pulses", 32'(err_pulses), 32'd2);
`endif

    for (int g = 0; g < 8; g++) begin
      stim.delete();
      for (int k = 0; k < 48; k++) begin
        case ($urandom_range(0, 9))
          0: stim.push_back(8'h7A);
          1: stim.push_back(8'h7B);
          2: stim.push_back(8'h7C);
          3: stim.push_back(8'h7D);
          default: stim.push_back(8'($urandom_range(0, 255)));
        endcase
      end
      run_group(stim, (g % 2 == 0) ? 1 : 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
